seg_display_arbiter: RTL
========================

# seg_display_arbiter

Shares one 4-digit common-anode seven-segment display between up to four requesters, such as FIFO write data, read data, count and status. A round-robin arbiter grants the whole display to one requester for a bounded hold time. The block also generates its own scan tick and digit multiplexing. It sits between the datapath's 8-bit observation buses and the board's `sm_wei`/`sm_duan` pins.

## Interface
- `DIV`, default 100000: clk cycles per scan tick; legal range ≥2.
- `HOLD`, default 1000: scan ticks per grant slot; legal range ≥2.
- `clk`  in  1  system clock; all state is on the rising edge.
- `rst_n`  in  1  reset; asynchronous assert, active-low. Clock and reset are fixed as one clock, async active-low reset.
- `req`  in  4  per-requester display request; bit i belongs to requester i; level-sensitive.
- `data`  in  32  requester i value on `data[8i+7:8i]`; displayed live, not latched.
- `grant`  out  4  one-hot grant; 0 when idle.
- `busy`  out  1  equals `|grant`.
- `sm_wei`  out  4  digit enables, active-low; bit k drives digit k.
- `sm_duan`  out  8  segments, active-low; bit7 = dp (always 1); bits6:0 = g..a.

## Operation
- **Tick generator.** `tcnt` counts 0..DIV-1 and wraps. `tick` is a 1-cycle pulse when `tcnt == DIV-1`.
- **Scan.**
  - 2-bit `dptr` increments on each tick and wraps 3→0.
  - Digit enable per `dptr`: 0 → `sm_wei = 4'b1110`, 1 → 1101, 2 → 1011, 3 → 0111.
- **Digit content while granted to requester g:**
  - digit0 = `data[g]` bits [3:0]
  - digit1 = `data[g]` bits [7:4]
  - digit2 = blank (0xFF)
  - digit3 = hex of g
- **Digit content while idle:** every digit shows a dash (0xBF).
- **Hex glyphs, 0..F:** C0, F9, A4, B0, 99, 92, 82, F8, 80, 90, 88, 83, C6, A1, 86, 8E.
- **FSM states.** IDLE and GRANT. `last` holds the 2-bit index of the most recent grant.
- **IDLE:**
  - If `req != 0`, grant the first requesting index searching `last+1, last+2, …` (mod 4).
  - Go to GRANT and clear `hcnt`.
- **GRANT (holding g):**
  - `hcnt` increments on each tick.
  - **Expiry** is a tick with `hcnt == HOLD-1`.
    - If another req bit is set, switch directly to the round-robin next requester. No IDLE cycle. `hcnt` clears.
    - Otherwise, if `req[g]` is still set, keep g and clear `hcnt`.
    - Otherwise go to IDLE.
  - **Early release** (`req[g] == 0` on any cycle):
    - Immediately re-arbitrate among the remaining requests: grant the next one, or go to IDLE if none.
    - Does not wait for a tick.
- **Round-robin scope.** `last` updates on every new grant, so the search always begins after the previous winner.
- **Display data source.** `data` is sampled every cycle, so the shown value follows the granted bus live.

## Timing
- **Reset values** (async, immediate on `rst_n` low):
  - `tcnt=0`, `dptr=0`, `hcnt=0`, `last=3`
  - FSM = IDLE, `grant=0`, `busy=0`
  - `sm_wei=4'b1111`, `sm_duan=8'hFF`
- **After reset.** `sm_wei` and `sm_duan` keep their reset values until the first tick. That first tick occurs DIV cycles after `rst_n` deasserts.
- **Grant latency.** `req` is sampled at edge N; `grant` and `busy` are valid after edge N+1. This is 1 cycle.
- **Output latency.** `sm_wei` and `sm_duan` are registered.
  - They reflect the `dptr`, `grant` and `data` of the previous cycle, so their latency is 1 cycle.
  - A grant change therefore reaches `sm_duan` 1 cycle after `grant` changes.
- **Slot length.** A slot lasts from the grant edge to the HOLD-th tick after it. Duration is between (HOLD-1)·DIV+1 and HOLD·DIV cycles, depending on tick phase. The tick phase is never reset by arbitration.
- **Simultaneous expiry and early release.** Early-release rules apply.
- **Reset mid-slot.** Everything returns to reset values. After release, the first grant goes to the lowest requesting index (because `last=3`).

## Test plan
All scenarios use DIV=4, HOLD=3.
- **Reset and idle.** Pulse `rst_n` low with `req=0`.
  - During reset: `sm_wei=1111`, `sm_duan=FF`, `grant=0`.
  - 4 cycles after release plus output latency: `sm_wei=1110`, `sm_duan=BF`.
- **Single requester.** Set `req=0010` and `data[15:8]=8'h3A`.
  - `grant=0010` and `busy=1` one cycle later.
  - Over one scan cycle `sm_duan` shows: digit0=88, digit1=B0, digit2=FF, digit3=F9.
- **Round-robin rotation.** Hold `req=1111` from reset.
  - Grants run 0001 → 0010 → 0100 → 1000 → 0001.
  - Each switch is on a tick edge, and each slot is ≤12 cycles.
- **Early release.** Set `req=0101`, with requester 0 granted first. Drop `req[0]` mid-slot.
  - `grant=0100` on the next cycle.
  - Drop `req[2]` too: `grant=0000` and `sm_duan` returns to BF.
- **Sole requester renewal.** Hold `req=1000` only, for 3 slots.
  - `grant` stays 1000 with no idle cycle at each expiry.
- **Async reset mid-slot.** Assert `rst_n=0` while `grant=0100`.
  - Outputs go to reset values within the same cycle.
  - With `req=1111` after release, the first grant is 0001.

Source files
------------

// File: rtl/seg_display_arbiter_if.sv
// seg_display_arbiter_if: requester-side bus and display pins of the shared seven-segment arbiter.
interface seg_display_arbiter_if;
    logic [3:0]  req;
    logic [31:0] data;
    logic [3:0]  grant;
    logic        busy;
    logic [3:0]  sm_wei;
    logic [7:0]  sm_duan;
    modport master (output req, data, input grant, busy, sm_wei, sm_duan);
    modport slave  (input req, data, output grant, busy, sm_wei, sm_duan);
endinterface

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: round-robin share of a 4-digit common-anode display with built-in scan.
module seg_display_arbiter #(
    parameter int DIV  = 100000,
    parameter int HOLD = 1000
) (
    input logic                  clk,
    input logic                  rst_n,
    seg_display_arbiter_if.slave bus
);
    localparam int TW = (DIV  > 2) ? $clog2(DIV)  : 1;
    localparam int HW = (HOLD > 2) ? $clog2(HOLD) : 1;
    localparam logic [7:0] HEX [16] = '{
        8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
        8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E
    };
    typedef enum logic {IDLE, GRANT} state_t;
    state_t        state_q;
    logic [TW-1:0] tcnt_q, tcnt_d;
    logic [HW-1:0] hcnt_q;
    logic [1:0]    dptr_q, dptr_d, gidx_q, last_q, pick;
    logic [3:0]    grant_q, wei_q, wei_d;
    logic [7:0]    duan_q, duan_d, sel_byte;
    logic          tick, expiry, found, started_q;
    assign tick   = tcnt_q == TW'(DIV - 1);
    assign expiry = tick && hcnt_q == HW'(HOLD - 1);
    assign tcnt_d = tick ? '0 : tcnt_q + 1'b1;
    assign dptr_d = tick ? dptr_q + 2'd1 : dptr_q;
    // Search last+1..last+4 so the previous winner is only chosen when it is the sole requester.
    always_comb begin
        found = 1'b0;
        pick  = last_q;
        for (int i = 4; i >= 1; i--) begin
            if (bus.req[last_q + 2'(i)]) begin
                found = 1'b1;
                pick  = last_q + 2'(i);
            end
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tcnt_q <= '0;
            dptr_q <= '0;
        end else begin
            tcnt_q <= tcnt_d;
            dptr_q <= dptr_d;
        end
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            gidx_q  <= 2'd0;
            last_q  <= 2'd3;
            grant_q <= '0;
            hcnt_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (found) begin
                    state_q <= GRANT;
                    gidx_q  <= pick;
                    last_q  <= pick;
                    grant_q <= 4'b0001 << pick;
                    hcnt_q  <= '0;
                end
                GRANT: if (!bus.req[gidx_q] || expiry) begin
                    hcnt_q <= '0;
                    if (found) begin
                        gidx_q  <= pick;
                        last_q  <= pick;
                        grant_q <= 4'b0001 << pick;
                    end else begin
                        state_q <= IDLE;
                        grant_q <= '0;
                    end
                end else if (tick) begin
                    hcnt_q <= hcnt_q + 1'b1;
                end
                default: state_q <= IDLE;
            endcase
        end
    end
    assign sel_byte = bus.data[{gidx_q, 3'b000} +: 8];
    assign wei_d    = ~(4'b0001 << dptr_q);
    assign duan_d   = (state_q == IDLE) ? 8'hBF :
                      (dptr_q == 2'd0)  ? HEX[sel_byte[3:0]] :
                      (dptr_q == 2'd1)  ? HEX[sel_byte[7:4]] :
                      (dptr_q == 2'd2)  ? 8'hFF : HEX[{2'b00, gidx_q}];
    // Pins stay dark until the first tick, then follow the scan one cycle behind.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            started_q <= 1'b0;
            wei_q     <= 4'hF;
            duan_q    <= 8'hFF;
        end else begin
            if (tick) started_q <= 1'b1;
            if (started_q || tick) begin
                wei_q  <= wei_d;
                duan_q <= duan_d;
            end
        end
    end
    assign bus.grant   = grant_q;
    assign bus.busy    = |grant_q;
    assign bus.sm_wei  = wei_q;
    assign bus.sm_duan = duan_q;
endmodule
